// File: rtl/cpu_log_checker.sv
// cpu_log_checker: streaming checker for CPU trace lines, one ASCII char per clk.
//   grf line: ^<time>@<pc>: $<reg> <= <data>#
//   mem line: ^<time>@<pc>: *<addr> <= <data>#
// Each line is classified, its fields are extracted into shadow accumulators,
// and the fields are committed to the outputs only when the whole line is
// accepted. The first error in a line is reported with a code, and the line
// is then dropped.
// Optional feature: define LOG_SEMANTIC_CHECK_EN to also reject lines at '#'
// whose pc falls outside [PC_LO, PC_HI] or is unaligned, whose grf number
// exceeds 31, or whose mem addr is unaligned (err_code 8).
module cpu_log_checker #(
  parameter int          TIME_MAX_DIGITS = 4,
  parameter int          GRF_MAX_DIGITS  = 4,
  parameter int          PC_DIGITS       = 8,
  parameter int          ADDR_DIGITS     = 8,
  parameter int          DATA_DIGITS     = 8,
  parameter int          TIME_W          = 16,
  parameter int          CNT_W           = 16,
  parameter logic [31:0] PC_LO           = 32'h3000,
  parameter logic [31:0] PC_HI           = 32'h6ffc
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  output logic [1:0]        format_type,
  output logic              err_valid,
  output logic [3:0]        err_code,
  output logic [TIME_W-1:0] time_val,
  output logic [31:0]       pc_val,
  output logic [31:0]       field_val,
  output logic [31:0]       data_val,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [7:0] T_MAX = 8'(TIME_MAX_DIGITS);
  localparam logic [7:0] G_MAX = 8'(GRF_MAX_DIGITS);
  localparam logic [7:0] PC_N  = 8'(PC_DIGITS);
  localparam logic [7:0] A_N   = 8'(ADDR_DIGITS);
  localparam logic [7:0] D_N   = 8'(DATA_DIGITS);

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_SEP, S_GRF, S_ADDR, S_SP1, S_LT, S_EQ_SP, S_DATA, S_DONE
  } state_t;

  // Shadow copy of the line being parsed; copied to the outputs on accept.
  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [31:0]       pc;
    logic [31:0]       fld;
    logic [31:0]       dat;
    logic              is_mem;
  } line_acc_t;

  state_t     state;
  line_acc_t  acc;
  logic [7:0] cnt;

  logic       c_dec, c_hex;
  logic [3:0] c_nib;
  logic       sem_bad;
  logic       bad;
  logic [3:0] bad_code;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Character class and nibble value of the current input char.
  always_comb begin
    c_dec = (char >= "0") && (char <= "9");
    c_hex = c_dec || ((char >= "a") && (char <= "f"));
    c_nib = c_dec ? 4'(char - "0") : 4'(char - "a" + 8'd10);
  end

`ifdef LOG_SEMANTIC_CHECK_EN
  assign sem_bad = (acc.pc < PC_LO) || (acc.pc > PC_HI) || (acc.pc[1:0] != 2'b00) ||
                   (!acc.is_mem && (acc.fld > 32'd31)) ||
                   (acc.is_mem && (acc.fld[1:0] != 2'b00));
`else
  // Syntax-only build: the pc window never rejects a line.
  assign sem_bad = 1'b0 && (PC_HI >= PC_LO);
`endif

  // Legality of the current char in the current state; '^' is handled in the FSM.
  always_comb begin
    bad      = 1'b0;
    bad_code = 4'd0;
    unique case (state)
      S_TIME: begin
        bad_code = 4'd1;
        if (c_dec)             bad = (cnt == T_MAX);
        else if (char == "@")  bad = (cnt == 8'd0);
        else                   bad = 1'b1;
      end
      S_PC: begin
        bad_code = 4'd2;
        if (c_hex)             bad = (cnt == PC_N);
        else if (char == ":")  bad = (cnt != PC_N);
        else                   bad = 1'b1;
      end
      S_SEP: begin
        bad_code = 4'd3;
        bad      = !((char == " ") || (char == "$") || (char == "*"));
      end
      S_GRF: begin
        bad_code = 4'd4;
        if (c_dec)                             bad = (cnt == G_MAX);
        else if ((char == " ") || (char == "<")) bad = (cnt == 8'd0);
        else                                   bad = 1'b1;
      end
      S_ADDR: begin
        bad_code = 4'd5;
        if (c_hex)                             bad = (cnt == A_N);
        else if ((char == " ") || (char == "<")) bad = (cnt != A_N);
        else                                   bad = 1'b1;
      end
      S_SP1: begin
        bad_code = 4'd6;
        bad      = !((char == " ") || (char == "<"));
      end
      S_LT: begin
        bad_code = 4'd6;
        bad      = (char != "=");
      end
      S_EQ_SP: begin
        bad_code = 4'd7;
        bad      = !((char == " ") || c_hex);
      end
      S_DATA: begin
        bad_code = 4'd7;
        if (c_hex)             bad = (cnt == D_N);
        else if (char == "#") begin
          if (cnt != D_N)      bad = 1'b1;
          else if (sem_bad) begin
            bad      = 1'b1;
            bad_code = 4'd8;
          end
        end
        else                   bad = 1'b1;
      end
      default: ;
    endcase
  end

  // Line FSM with registered result pulses, counters and committed fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      format_type <= 2'b00;
      err_valid   <= 1'b0;
      err_code    <= 4'd0;
      time_val    <= '0;
      pc_val      <= '0;
      field_val   <= '0;
      data_val    <= '0;
      ok_cnt      <= '0;
      err_cnt     <= '0;
    end else begin
      format_type <= 2'b00;
      err_valid   <= 1'b0;
      if (char == "^") begin
        if ((state != S_IDLE) && (state != S_DONE)) begin
          err_valid <= 1'b1;
          err_code  <= 4'd9;
          err_cnt   <= sat_inc(err_cnt);
        end
        state <= S_TIME;
        cnt   <= '0;
        acc   <= '0;
      end else if (bad) begin
        err_valid <= 1'b1;
        err_code  <= bad_code;
        err_cnt   <= sat_inc(err_cnt);
        state     <= S_IDLE;
      end else begin
        case (state)
          S_TIME:
            if (c_dec) begin
              cnt   <= cnt + 8'd1;
              acc.t <= acc.t * TIME_W'(10) + TIME_W'(c_nib);
            end else begin
              cnt   <= '0;
              state <= S_PC;
            end
          S_PC:
            if (c_hex) begin
              cnt    <= cnt + 8'd1;
              acc.pc <= {acc.pc[27:0], c_nib};
            end else begin
              cnt   <= '0;
              state <= S_SEP;
            end
          S_SEP:
            if (char == "$") begin
              acc.is_mem <= 1'b0;
              state      <= S_GRF;
            end else if (char == "*") begin
              acc.is_mem <= 1'b1;
              state      <= S_ADDR;
            end
          S_GRF:
            if (c_dec) begin
              cnt     <= cnt + 8'd1;
              acc.fld <= acc.fld * 32'd10 + 32'(c_nib);
            end else begin
              state <= (char == "<") ? S_LT : S_SP1;
            end
          S_ADDR:
            if (c_hex) begin
              cnt     <= cnt + 8'd1;
              acc.fld <= {acc.fld[27:0], c_nib};
            end else begin
              state <= (char == "<") ? S_LT : S_SP1;
            end
          S_SP1:
            if (char == "<") state <= S_LT;
          S_LT:
            state <= S_EQ_SP;
          S_EQ_SP:
            if (c_hex) begin
              cnt     <= 8'd1;
              acc.dat <= 32'(c_nib);
              state   <= S_DATA;
            end
          S_DATA:
            if (c_hex) begin
              cnt     <= cnt + 8'd1;
              acc.dat <= {acc.dat[27:0], c_nib};
            end else begin
              // '#' with a full data field and no semantic objection.
              state       <= S_DONE;
              format_type <= acc.is_mem ? 2'b10 : 2'b01;
              time_val    <= acc.t;
              pc_val      <= acc.pc;
              field_val   <= acc.fld;
              data_val    <= acc.dat;
              ok_cnt      <= sat_inc(ok_cnt);
            end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_log_checker.sv
// Bench for cpu_log_checker: a table of hand-written lines with expected
// verdicts, a few multi-cycle sequences, and randomly built lines whose
// verdict is known from how they were constructed.
module tb_cpu_log_checker;

`ifdef LOG_SEMANTIC_CHECK_EN
  localparam bit SEM_EN = 1'b1;
`else
  localparam bit SEM_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  char;
  logic [1:0]  format_type;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [15:0] time_val;
  logic [31:0] pc_val, field_val, data_val;
  logic [15:0] ok_cnt, err_cnt;

  cpu_log_checker dut (
    .clk(clk), .reset(reset), .char(char),
    .format_type(format_type), .err_valid(err_valid), .err_code(err_code),
    .time_val(time_val), .pc_val(pc_val), .field_val(field_val), .data_val(data_val),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       line;
    int          kind;   // 0 rejected, 1 grf ok, 2 mem ok
    int          code;   // first error code, 0 if none
    int unsigned t, pc, fld, dat;
  } vec_t;

  vec_t vt[$];
  int   q_err[$];
  int   q_fmt[$];
  int   n_cmp = 0, n_bad = 0;
  int unsigned m_time = 0, m_pc = 0, m_fld = 0, m_dat = 0, m_ok = 0, m_err = 0;

  // Record every result pulse, sampled half a cycle away from the edge.
  always @(negedge clk) begin
    if (err_valid) q_err.push_back(int'(err_code));
    if (format_type != 2'b00) q_fmt.push_back(int'(format_type));
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] c);
    char = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string l, input int k, input int c, input int unsigned t,
                     input int unsigned pc, input int unsigned f, input int unsigned d);
    vec_t v;
    v.line = l; v.kind = k; v.code = c; v.t = t; v.pc = pc; v.fld = f; v.dat = d;
    vt.push_back(v);
  endtask

  function automatic string sp(input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, " "};
    return s;
  endfunction

  task automatic check_fields(input string tag);
    chk({tag, "/time"}, time_val, m_time);
    chk({tag, "/pc"},   pc_val,   m_pc);
    chk({tag, "/fld"},  field_val, m_fld);
    chk({tag, "/data"}, data_val, m_dat);
    chk({tag, "/ok"},   ok_cnt,   m_ok);
    chk({tag, "/err"},  err_cnt,  m_err);
  endtask

  // Feed one item and compare the pulses it produced and the state it left.
  task automatic run_item(input string tag, input string s, input int kind, input int nerr,
                          input int e0, input int e1, input int unsigned t,
                          input int unsigned pc, input int unsigned f, input int unsigned d);
    q_err.delete();
    q_fmt.delete();
    for (int i = 0; i < s.len(); i++) put(s[i]);
    put(" ");
    put(" ");
    chk({tag, "/nerr"}, q_err.size(), nerr);
    if (nerr > 0 && q_err.size() > 0) chk({tag, "/code0"}, q_err[0], e0);
    if (nerr > 1 && q_err.size() > 1) chk({tag, "/code1"}, q_err[1], e1);
    chk({tag, "/nfmt"}, q_fmt.size(), (kind != 0) ? 1 : 0);
    if (kind != 0 && q_fmt.size() > 0) chk({tag, "/fmt"}, q_fmt[0], kind);
    if (kind != 0) begin
      m_time = t; m_pc = pc; m_fld = f; m_dat = d; m_ok++;
    end
    m_err += nerr;
    check_fields(tag);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    string s, ts, ps, fs, ds, mk, lt, line;
    int unsigned tv, pcv, rg, ad, dv, fv;
    int f, kind, nerr, e0, e1, k;
    bit mem, sem;

    reset = 1'b0;
    char  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/fmt", format_type, 0);
    chk("rst/errv", err_valid, 0);
    chk("rst/code", err_code, 0);
    check_fields("rst");
    reset = 1'b1;
    put(" ");

    add("^10@00003000: $1 <= 0000000a#",            1, 0, 10, 'h3000, 1, 'ha);
    add("^7@00003004: *0000001c<=  12345678#",      2, 0, 7, 'h3004, 'h1c, 'h12345678);
    add("^12345@",                                  0, 1, 0, 0, 0, 0);
    add("^@00003000: $1 <= 00000000#",              0, 1, 0, 0, 0, 0);
    add("^1@0000300: $1 <= 00000000#",              0, 2, 0, 0, 0, 0);
    add("^1@000030000",                             0, 2, 0, 0, 0, 0);
    add("^1@0000300A",                              0, 2, 0, 0, 0, 0);
    add("^1@00003000:x",                            0, 3, 0, 0, 0, 0);
    add("^1@00003000: $12345",                      0, 4, 0, 0, 0, 0);
    add("^1@00003000: $ <",                         0, 4, 0, 0, 0, 0);
    add("^1@00003000: *0000001 <",                  0, 5, 0, 0, 0, 0);
    add("^1@00003000: $1 x",                        0, 6, 0, 0, 0, 0);
    add("^1@00003000: $1 <x",                       0, 6, 0, 0, 0, 0);
    add("^1@00003000: $1 <= 1234567#",              0, 7, 0, 0, 0, 0);
    add("^1@00003000: $1 <= 123456789",             0, 7, 0, 0, 0, 0);
    if (SEM_EN) add("^1@00002ffc: $40 <= 00000001#", 0, 8, 0, 0, 0, 0);
    else        add("^1@00002ffc: $40 <= 00000001#", 1, 0, 1, 'h2ffc, 40, 1);
    add("^9@0000300c: $031<=ffffffff#",             1, 0, 9, 'h300c, 31, 'hffffffff);
    add("^9999@00006ffc: *00000000 <= deadbeef#",   2, 0, 9999, 'h6ffc, 0, 'hdeadbeef);
    add("^1@00003000: $1 <= 0000000g#",             0, 7, 0, 0, 0, 0);
    add("^1@00003000: $1 <= #",                     0, 7, 0, 0, 0, 0);
    add("^1@0000300^2@00003000: $3 <= 00000000#",   1, 9, 2, 'h3000, 3, 0);
    add("^3@00003000:   *00000010   <=   00000010#", 2, 0, 3, 'h3000, 'h10, 'h10);

    for (int i = 0; i < vt.size(); i++)
      run_item($sformatf("vec%0d", i), vt[i].line, vt[i].kind, (vt[i].code != 0) ? 1 : 0,
               vt[i].code, 0, vt[i].t, vt[i].pc, vt[i].fld, vt[i].dat);

    // Back-to-back lines: latency 1 on accept, pulse gone one edge later.
    q_err.delete();
    q_fmt.delete();
    s = "^7@00003004: *0000001c<=  12345678#";
    for (int i = 0; i < s.len(); i++) put(s[i]);
    chk("b2b/fmt1", format_type, 2);
    chk("b2b/fld1", field_val, 'h1c);
    chk("b2b/ok1", ok_cnt, m_ok + 1);
    m_ok++; m_time = 7; m_pc = 'h3004; m_fld = 'h1c; m_dat = 'h12345678;
    s = "^8@00003008: $2 <= 00000002#";
    put(s[0]);
    chk("b2b/fmt_drop", format_type, 0);
    for (int i = 1; i < s.len(); i++) put(s[i]);
    chk("b2b/fmt2", format_type, 1);
    chk("b2b/time2", time_val, 8);
    put(" ");
    put(" ");
    chk("b2b/nerr", q_err.size(), 0);
    chk("b2b/nfmt", q_fmt.size(), 2);
    m_ok++; m_time = 8; m_pc = 'h3008; m_fld = 2; m_dat = 2;
    check_fields("b2b");

    // Reset in the middle of the data field clears everything at once.
    s = "^5@00003000: $1 <= 000";
    for (int i = 0; i < s.len(); i++) put(s[i]);
    reset = 1'b0;
    #2;
    chk("mrst/fmt", format_type, 0);
    chk("mrst/errv", err_valid, 0);
    chk("mrst/code", err_code, 0);
    m_time = 0; m_pc = 0; m_fld = 0; m_dat = 0; m_ok = 0; m_err = 0;
    check_fields("mrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_item("mrst/line", "^5@00003000: $1 <= 00000007#", 1, 0, 0, 0, 5, 'h3000, 1, 7);

    // Random lines, each either well-formed or carrying one known fault.
    for (int it = 0; it < 250; it++) begin
      tv  = $urandom_range(0, 9999);
      pcv = $urandom_range(0, 1) ? (32'h3000 + 4 * $urandom_range(0, 4095)) : $urandom;
      mem = 1'($urandom_range(0, 1));
      ad  = $urandom;
      if ($urandom_range(0, 1) != 0) ad = ad & ~32'd3;
      rg  = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 9999);
      dv  = $urandom;
      ts  = $sformatf("%0d", tv);
      ps  = $sformatf("%08h", pcv);
      fs  = mem ? $sformatf("%08h", ad) : $sformatf("%0d", rg);
      ds  = $sformatf("%08h", dv);
      mk  = mem ? "*" : "$";
      lt  = "<=";
      f   = $urandom_range(0, 11);
      e0 = 0; e1 = 0; nerr = 0; kind = 0;
      case (f)
        4:  begin ts = $sformatf("%0d", $urandom_range(10000, 99999)); e0 = 1; end
        5:  begin ps = ps.substr(1, 7); e0 = 2; end
        6:  begin mk = "x"; e0 = 3; end
        7:  if (mem) begin fs = {"0", fs}; e0 = 5; end
            else begin fs = $sformatf("%0d", $urandom_range(10000, 99999)); e0 = 4; end
        8:  begin lt = "<>"; e0 = 6; end
        9:  begin ds = ds.substr(1, 7); e0 = 7; end
        10: begin ds = {ds.substr(0, 2), "G", ds.substr(4, 7)}; e0 = 7; end
        default: ;
      endcase
      line = {"^", ts, "@", ps, ":", sp($urandom_range(0, 2)), mk, fs,
              sp($urandom_range(0, 2)), lt, sp($urandom_range(0, 2)), ds, "#"};
      if (e0 != 0) nerr = 1;
      else begin
        sem = SEM_EN && ((pcv < 32'h3000) || (pcv > 32'h6ffc) || (pcv % 4 != 0) ||
                         (!mem && rg > 31) || (mem && ad % 4 != 0));
        if (sem) begin nerr = 1; e0 = 8; end
        else kind = mem ? 2 : 1;
      end
      s = line;
      if (f == 11) begin
        k = $urandom_range(0, line.len() - 2);
        s = {line.substr(0, k), line};
        e1 = e0;
        e0 = 9;
        nerr++;
      end
      fv = mem ? ad : rg;
      run_item($sformatf("rnd%0d", it), s, kind, nerr, e0, e1, tv, pcv, fv, dv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
